// File: rtl/pipe_stage_skid.sv
// One pipeline stage with valid/ready handshake, optional skid entry,
// exception/flush squash and a saturating back-pressure counter.
module pipe_stage_skid #(
    parameter int              PAYLOAD_W = 64,
    parameter int              PC_W      = 32,
    parameter logic [PC_W-1:0] RESET_PC  = 32'h0000_3000,
    parameter logic [PC_W-1:0] EXC_PC    = 32'h0000_4180,
    parameter bit              SKID      = 1'b1,
    parameter int              CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PC_W-1:0]      in_pc,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PC_W-1:0]      out_pc,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [1:0]           occupancy,
    output logic [CNT_W-1:0]     stall_cnt
);

    logic                 skid_valid;
    logic [PC_W-1:0]      skid_pc;
    logic [PAYLOAD_W-1:0] skid_payload;

    logic                 main_valid_n;
    logic [PC_W-1:0]      main_pc_n;
    logic [PAYLOAD_W-1:0] main_payload_n;
    logic                 skid_valid_n;
    logic [PC_W-1:0]      skid_pc_n;
    logic [PAYLOAD_W-1:0] skid_payload_n;
    logic [CNT_W-1:0]     stall_cnt_n;
    logic                 accept;
    logic                 drain;

    // With a skid entry, ready depends only on stored state, breaking the
    // combinational out_ready -> in_ready path.
    generate
        if (SKID) begin : g_skid_ready
            assign in_ready = !skid_valid;
        end else begin : g_single_ready
            assign in_ready = !out_valid || out_ready;
        end
    endgenerate

    assign accept = in_valid && in_ready;
    assign drain  = out_valid && out_ready;

    always_comb begin
        main_valid_n   = out_valid;
        main_pc_n      = out_pc;
        main_payload_n = out_payload;
        skid_valid_n   = skid_valid;
        skid_pc_n      = skid_pc;
        skid_payload_n = skid_payload;
        stall_cnt_n    = stall_cnt;

        if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt_n = stall_cnt + CNT_W'(1);

        if (req || flush) begin
            // Squash: the bubble carries EXC_PC on redirect, else the killed PC.
            main_valid_n   = 1'b0;
            main_pc_n      = req ? EXC_PC : in_pc;
            main_payload_n = '0;
            skid_valid_n   = 1'b0;
            skid_pc_n      = '0;
            skid_payload_n = '0;
        end else if (SKID) begin
            if (!out_valid || drain) begin
                if (skid_valid) begin
                    main_valid_n   = 1'b1;
                    main_pc_n      = skid_pc;
                    main_payload_n = skid_payload;
                    skid_valid_n   = accept;
                    if (accept) begin
                        skid_pc_n      = in_pc;
                        skid_payload_n = in_payload;
                    end
                end else if (accept) begin
                    main_valid_n   = 1'b1;
                    main_pc_n      = in_pc;
                    main_payload_n = in_payload;
                end else begin
                    main_valid_n = 1'b0;
                end
            end else if (accept) begin
                skid_valid_n   = 1'b1;
                skid_pc_n      = in_pc;
                skid_payload_n = in_payload;
            end
        end else begin
            if (accept) begin
                main_valid_n   = 1'b1;
                main_pc_n      = in_pc;
                main_payload_n = in_payload;
            end else if (drain) begin
                main_valid_n = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid    <= 1'b0;
            out_pc       <= RESET_PC;
            out_payload  <= '0;
            skid_valid   <= 1'b0;
            skid_pc      <= '0;
            skid_payload <= '0;
            occupancy    <= 2'd0;
            stall_cnt    <= '0;
        end else begin
            out_valid    <= main_valid_n;
            out_pc       <= main_pc_n;
            out_payload  <= main_payload_n;
            skid_valid   <= skid_valid_n;
            skid_pc      <= skid_pc_n;
            skid_payload <= skid_payload_n;
            occupancy    <= {1'b0, main_valid_n} + {1'b0, skid_valid_n};
            stall_cnt    <= stall_cnt_n;
        end
    end

endmodule
